shift_sched: RTL and testbench

Scheduler in front of the `shift_reg` serialiser of the display chain. Two frame producers (A: time display, B: status LEDs) share one shift register; this block arbitrates round-robin, captures the winning frame, pulses the shifter's start, waits for its latch pulse as completion, and acknowledges the requester. A completion timeout flags a stuck shifter, and an optional periodic refresh re-sends the last frame so that display glitches self-heal.

---
 rtl/shift_sched.sv | 168 ++++++++++++++++
 tb/tb_shift_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - round-robin scheduler feeding one shift_reg from two frame producers
// Optional periodic re-send of the last frame: define SHIFT_SCHED_REFRESH_EN.
module shift_sched #(
    parameter int WIDTH          = 48,
    parameter int TIMEOUT        = 4096,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_a_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic             req_b_i,
    input  logic [WIDTH-1:0] data_b_i,
    output logic             ack_a_o,
    output logic             ack_b_o,
    output logic             sr_start_o,
    output logic [WIDTH-1:0] sr_data_o,
    input  logic             sr_latch_i,
    output logic             busy_o,
    output logic             err_o
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_LATCH, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_A, OWN_B, OWN_REFRESH} owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic               last_b_q, last_b_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               latch_prev_q;

    logic grant_a, grant_b, grant_r, refresh_due, latch_edge;

    assign latch_edge = sr_latch_i && !latch_prev_q;

    // Contention goes to whoever was not granted last; refresh only fills a fully idle slot.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        grant_r = 1'b0;
        if (state_q == S_IDLE) begin
            if (req_a_i && req_b_i) begin
                grant_a = last_b_q;
                grant_b = !last_b_q;
            end else begin
                grant_a = req_a_i;
                grant_b = req_b_i;
                grant_r = refresh_due && !req_a_i && !req_b_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_b_d = last_b_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_a) begin
                    state_d  = S_START;
                    owner_d  = OWN_A;
                    last_b_d = 1'b0;
                    data_d   = data_a_i;
                end else if (grant_b) begin
                    state_d  = S_START;
                    owner_d  = OWN_B;
                    last_b_d = 1'b1;
                    data_d   = data_b_i;
                end else if (grant_r) begin
                    state_d  = S_START;
                    owner_d  = OWN_REFRESH;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_LATCH;
            end
            S_WAIT_LATCH: begin
                if (latch_edge) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_A;
            last_b_q     <= 1'b1;
            data_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            latch_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_b_q     <= last_b_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            latch_prev_q <= sr_latch_i;
        end
    end

`ifdef SHIFT_SCHED_REFRESH_EN
    localparam int IDLE_W = $clog2(REFRESH_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              frame_valid_q, frame_valid_d;

    // No refresh until some frame has actually been latched since reset.
    assign refresh_due = frame_valid_q && (idle_cnt_q == IDLE_W'(REFRESH_CYCLES - 1));

    always_comb begin
        idle_cnt_d    = idle_cnt_q;
        frame_valid_d = frame_valid_q;
        if (state_q == S_DONE) begin
            frame_valid_d = 1'b1;
        end
        if (state_q == S_IDLE) begin
            if (grant_a || grant_b || grant_r) begin
                idle_cnt_d = '0;
            end else if (frame_valid_q) begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            frame_valid_q <= frame_valid_d;
        end
    end
`else
    // Purely request-driven; the term keeps REFRESH_CYCLES referenced and is always 0.
    assign refresh_due = (REFRESH_CYCLES < 0);
`endif

    assign sr_start_o = (state_q == S_START);
    assign sr_data_o  = data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign ack_a_o    = (state_q == S_DONE) && (owner_q == OWN_A);
    assign ack_b_o    = (state_q == S_DONE) && (owner_q == OWN_B);
    assign err_o      = err_q;

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - directed bench for shift_sched with a transaction-timeline reference model
module tb_shift_sched;
    localparam int WIDTH          = 48;
    localparam int TIMEOUT        = 64;
    localparam int REFRESH_CYCLES = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_a = 1'b0, req_b = 1'b0, latch = 1'b0;
    logic [WIDTH-1:0] data_a = '0, data_b = '0;
    logic             ack_a, ack_b, sr_start, busy, err;
    logic [WIDTH-1:0] sr_data;

    shift_sched #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .REFRESH_CYCLES(REFRESH_CYCLES)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_a_i(req_a), .data_a_i(data_a),
        .req_b_i(req_b), .data_b_i(data_b),
        .ack_a_o(ack_a), .ack_b_o(ack_b),
        .sr_start_o(sr_start), .sr_data_o(sr_data),
        .sr_latch_i(latch), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one transfer is a timeline of cycle numbers (grant, latch edge, return to idle).
    bit               m_busy, m_err, m_last_b, m_prev_latch, m_frame_valid;
    int               m_grant_cyc, m_done_cyc, m_idle_start, m_owner;
    logic [WIDTH-1:0] m_data;
    bit               e_start, e_ack_a, e_ack_b, edge_seen, want_a, want_b, want_r;

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_last_b = 1; m_prev_latch = 0; m_frame_valid = 0;
        m_grant_cyc = 0; m_done_cyc = -1; m_idle_start = 0; m_owner = 0; m_data = '0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {ack_a, ack_b, sr_start, busy, err}, '0);
            chk("reset_data", sr_data, '0);
            model_reset();
        end else begin
            e_start = m_busy && (cyc == m_grant_cyc + 1);
            e_ack_a = m_busy && (m_done_cyc >= 0) && (cyc == m_done_cyc + 1) && (m_owner == 0);
            e_ack_b = m_busy && (m_done_cyc >= 0) && (cyc == m_done_cyc + 1) && (m_owner == 1);
            chk("model_start", sr_start, e_start);
            chk("model_ack_a", ack_a, e_ack_a);
            chk("model_ack_b", ack_b, e_ack_b);
            chk("model_busy", busy, m_busy);
            chk("model_err", err, m_err);
            chk("model_data", sr_data, m_data);

            edge_seen = latch && !m_prev_latch;
            if (!m_busy) begin
                want_a = req_a && (!req_b || m_last_b);
                want_b = req_b && !want_a;
`ifdef SHIFT_SCHED_REFRESH_EN
                want_r = !req_a && !req_b && m_frame_valid
                         && (cyc - m_idle_start == REFRESH_CYCLES - 1);
`else
                want_r = 0;
`endif
                if (want_a || want_b || want_r) begin
                    m_busy = 1;
                    m_grant_cyc = cyc;
                    m_done_cyc = -1;
                    if (want_a) begin
                        m_owner = 0; m_data = data_a; m_last_b = 0;
                    end else if (want_b) begin
                        m_owner = 1; m_data = data_b; m_last_b = 1;
                    end else begin
                        m_owner = 2;
                    end
                end
            end else if (m_done_cyc < 0) begin
                if (cyc >= m_grant_cyc + 2) begin
                    if (edge_seen) begin
                        m_done_cyc = cyc;
                    end else if (cyc == m_grant_cyc + 1 + TIMEOUT) begin
                        m_err = 1; m_busy = 0; m_idle_start = cyc + 1;
                    end
                end
            end else if (cyc == m_done_cyc + 1) begin
                m_busy = 0; m_frame_valid = 1; m_idle_start = cyc + 1;
            end
            m_prev_latch = latch;
        end
    end

    byte ack_log[$];
    always @(negedge clk) begin
        if (!rst && ack_a) ack_log.push_back(8'h41);
        if (!rst && ack_b) ack_log.push_back(8'h42);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_n(3);
        rst = 1'b0;
    endtask

    task automatic pulse_latch();
        latch = 1'b1;
        tick();
        latch = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (sr_start) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(name, ok, 1'b1);
    endtask

    int t0, lat, d1, d2;

    initial begin
        tick_n(2);

        // Single A transfer with a slow shifter
        do_reset();
        chk("idle_after_reset", {ack_a, ack_b, sr_start, busy, err}, '0);
        tick();
        t0 = cyc;
        req_a = 1'b1;
        data_a = 48'hA5A5_0000_1234;
        tick();
        chk("t1_start", sr_start, 1'b1);
        chk("t1_data", sr_data, 48'hA5A5_0000_1234);
        tick();
        chk("t1_start_one_cycle", sr_start, 1'b0);
        chk("t1_busy", busy, 1'b1);
        tick_to(t0 + 51);
        lat = cyc;
        pulse_latch();
        chk("t1_ack_cycle", ack_a, 1'b1);
        tick();
        chk("t1_busy_fall", busy, 1'b0);
        chk("t1_ack_one_cycle", ack_a, 1'b0);
        chk("t1_ack_at_latch_plus1", cyc, lat + 2);
        req_a = 1'b0;
        tick_n(2);

        // Both requesters held: grants alternate, A first after reset
        do_reset();
        ack_log.delete();
        data_a = 48'h0000_0000_00A1;
        data_b = 48'h0000_0000_00B2;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start("t2_start_seen");
            tick_n(10);
            pulse_latch();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick_n(3);
        chk("t2_ack_count", ack_log.size(), 4);
        chk("t2_order0", ack_log[0], 8'h41);
        chk("t2_order1", ack_log[1], 8'h42);
        chk("t2_order2", ack_log[2], 8'h41);
        chk("t2_order3", ack_log[3], 8'h42);

        // Stuck shifter: timeout, sticky err, held request restarts
        do_reset();
        ack_log.delete();
        data_b = 48'h1234_5678_9ABC;
        req_b = 1'b1;
        t0 = cyc;
        tick_to(t0 + TIMEOUT + 1);
        chk("t3_err_not_yet", err, 1'b0);
        chk("t3_still_busy", busy, 1'b1);
        tick();
        chk("t3_err_set", err, 1'b1);
        chk("t3_idle_after_abort", busy, 1'b0);
        tick();
        chk("t3_restart", sr_start, 1'b1);
        chk("t3_no_ack_on_abort", ack_log.size(), 0);
        tick_n(3);
        pulse_latch();
        chk("t3_ack_after_restart", ack_b, 1'b1);
        chk("t3_err_sticky", err, 1'b1);
        req_b = 1'b0;
        tick_n(2);

        // Reset in the middle of WAIT_LATCH
        do_reset();
        ack_log.delete();
        req_a = 1'b1;
        data_a = 48'h0F0F_F0F0_5555;
        tick_n(5);
        chk("t4_busy_before_reset", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("t4_async_clear", {ack_a, ack_b, sr_start, busy, err}, '0);
        chk("t4_async_data", sr_data, '0);
        req_a = 1'b0;
        tick_n(2);
        rst = 1'b0;
        tick_n(3);
        pulse_latch();
        tick_n(3);
        chk("t4_no_ack", ack_log.size(), 0);

`ifdef SHIFT_SCHED_REFRESH_EN
        // Periodic refresh after one B transfer, then A pre-empts a due refresh
        do_reset();
        ack_log.delete();
        data_b = 48'hBEEF_0000_CAFE;
        req_b = 1'b1;
        wait_start("t5_b_start_seen");
        tick_n(3);
        pulse_latch();
        d1 = cyc;
        chk("t5_ack_b", ack_b, 1'b1);
        req_b = 1'b0;
        data_b = 48'h0000_0000_0001;
        tick_to(d1 + REFRESH_CYCLES);
        chk("t5_not_early", {sr_start, busy}, '0);
        tick();
        chk("t5_refresh_start", sr_start, 1'b1);
        chk("t5_refresh_data", sr_data, 48'hBEEF_0000_CAFE);
        tick_n(3);
        pulse_latch();
        d2 = cyc;
        chk("t5_refresh_no_ack", {ack_a, ack_b}, '0);
        tick_to(d2 + REFRESH_CYCLES);
        req_a = 1'b1;
        data_a = 48'h0000_1111_2222;
        tick();
        chk("t5_a_wins", sr_start, 1'b1);
        chk("t5_a_data", sr_data, 48'h0000_1111_2222);
        tick_n(3);
        pulse_latch();
        chk("t5_ack_a", ack_a, 1'b1);
        req_a = 1'b0;
        tick_n(2);
        chk("t5_ack_total", ack_log.size(), 2);
`endif

        tick_n(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
